// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and Set-2 byte constants for the PS/2 scancode controller
package ps2_pkg;
    typedef struct packed {
        logic       brk;
        logic       ext;
        logic [7:0] key;
    } key_event_t;
    typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, PAUSE} state_t;
    localparam logic [7:0] PFX_EXT   = 8'hE0;
    localparam logic [7:0] PFX_BRK   = 8'hF0;
    localparam logic [7:0] PFX_PAUSE = 8'hE1;
    localparam logic [7:0] BAT_OK    = 8'hAA;
    localparam logic [7:0] ACK       = 8'hFA;
    localparam logic [7:0] ECHO      = 8'hEE;
    localparam logic [7:0] BAT_ERR   = 8'hFC;
    localparam logic [7:0] OVR0      = 8'h00;
    localparam logic [7:0] OVR1      = 8'hFF;
    localparam logic [7:0] PAUSE_KEY = 8'h77;
    localparam int         PAUSE_SKIP = 7;
    function automatic key_event_t mk_ev(logic brk, logic ext, logic [7:0] key);
        return '{brk: brk, ext: ext, key: key};
    endfunction
endpackage

// File: rtl/ps2_scancode_controller_fifo.sv
// ps2_event_fifo: small key-event FIFO with show-ahead output
// Ports: clk/rst (async, active-high); push/din write side; pop/dout read side;
// empty/full status. A push while full is dropped unless a pop happens in the same cycle.
module ps2_event_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  key_event_t din,
    input  logic       pop,
    output key_event_t dout,
    output logic       empty,
    output logic       full
);
    localparam int AW = $clog2(DEPTH);
    logic [AW:0] wr_ptr, rd_ptr;
    key_event_t  mem [DEPTH];
    logic        do_pop, do_push;
    assign empty   = wr_ptr == rd_ptr;
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    // Head reads as zero while empty so ev_data is defined without resetting storage
    assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/ps2_scancode_controller.sv
// ps2_scancode_controller: turns decoder bytes into Set-2 key events buffered in a FIFO
// Ports: clk/rst (async, active-high); code/done from the decoder; ev_valid/ev_ready/ev_data
// host handshake; kb_ready sticky self-test pass; overflow sticky dropped event;
// err_cnt saturating error count (timeouts and keyboard error codes).
module ps2_scancode_controller
    import ps2_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int TIMEOUT_CYC = 50000,
    parameter int ERR_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       code,
    input  logic             done,
    output logic             ev_valid,
    input  logic             ev_ready,
    output key_event_t       ev_data,
    output logic             kb_ready,
    output logic             overflow,
    output logic [ERR_W-1:0] err_cnt
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    state_t     state, state_nx;
    logic [2:0] skip, skip_nx;
    logic [TW-1:0] timer;
    logic       push, err_inc, set_kb, empty, full, pop, timeout;
    key_event_t ev;
    assign ev_valid = !empty;
    assign pop      = ev_valid && ev_ready;
    assign timeout  = (state != IDLE) && (timer == TW'(TIMEOUT_CYC - 1));
    ps2_event_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (ev),
        .pop   (pop),
        .dout  (ev_data),
        .empty (empty),
        .full  (full)
    );
    always_comb begin
        state_nx = state;
        skip_nx  = skip;
        push     = 1'b0;
        ev       = '0;
        err_inc  = 1'b0;
        set_kb   = 1'b0;
        // A byte arriving in the timeout cycle takes priority over the timeout
        if (done) begin
            case (state)
                IDLE: case (code)
                    PFX_EXT:   state_nx = EXT;
                    PFX_BRK:   state_nx = BRK;
                    PFX_PAUSE: begin
                        state_nx = PAUSE;
                        skip_nx  = 3'(PAUSE_SKIP);
                    end
                    BAT_OK:    set_kb = 1'b1;
                    ACK, ECHO: ;
                    BAT_ERR, OVR0, OVR1: err_inc = 1'b1;
                    default: begin
                        push = 1'b1;
                        ev   = mk_ev(1'b0, 1'b0, code);
                    end
                endcase
                EXT: begin
                    if (code == PFX_BRK) state_nx = EXT_BRK;
                    else if (code != PFX_EXT) begin
                        push     = 1'b1;
                        ev       = mk_ev(1'b0, 1'b1, code);
                        state_nx = IDLE;
                    end
                end
                BRK: begin
                    push     = 1'b1;
                    ev       = mk_ev(1'b1, 1'b0, code);
                    state_nx = IDLE;
                end
                EXT_BRK: begin
                    push     = 1'b1;
                    ev       = mk_ev(1'b1, 1'b1, code);
                    state_nx = IDLE;
                end
                PAUSE: begin
                    skip_nx = skip - 3'd1;
                    if (skip == 3'd1) begin
                        push     = 1'b1;
                        ev       = mk_ev(1'b0, 1'b1, PAUSE_KEY);
                        state_nx = IDLE;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end else if (timeout) begin
            state_nx = IDLE;
            err_inc  = 1'b1;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            skip     <= '0;
            timer    <= '0;
            err_cnt  <= '0;
            kb_ready <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nx;
            skip     <= skip_nx;
            timer    <= (done || state == IDLE || timeout) ? '0 : timer + TW'(1);
            err_cnt  <= (err_inc && !(&err_cnt)) ? err_cnt + ERR_W'(1) : err_cnt;
            kb_ready <= kb_ready | set_kb;
            overflow <= overflow | (push && full && !pop);
        end
    end
endmodule

// File: tb/tb_ps2_scancode_controller.sv
// tb_ps2_scancode_controller: directed bench with a queue-based reference model checked every cycle
module tb_ps2_scancode_controller;
    localparam int DEPTH = 4;
    localparam int TO    = 20;
    localparam int EW    = 3;
    logic          clk = 0, rst = 1, done = 0, ev_ready = 0;
    logic [7:0]    code = 0;
    logic          ev_valid, kb_ready, overflow;
    logic [9:0]    ev_data;
    logic [EW-1:0] err_cnt;
    int n_chk = 0, n_pass = 0;
    logic [9:0] m_q[$];
    logic [7:0] pend[$];
    bit         m_kb = 0, m_ovf = 0;
    int         m_err = 0, m_cnt = 0;

    always #5 clk = ~clk;

    ps2_scancode_controller #(.DEPTH(DEPTH), .TIMEOUT_CYC(TO), .ERR_W(EW)) dut (
        .clk      (clk),
        .rst      (rst),
        .code     (code),
        .done     (done),
        .ev_valid (ev_valid),
        .ev_ready (ev_ready),
        .ev_data  (ev_data),
        .kb_ready (kb_ready),
        .overflow (overflow),
        .err_cnt  (err_cnt)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    function automatic int sat(input int v);
        return (v < (2**EW) - 1) ? v + 1 : v;
    endfunction

    // Reference: the partial sequence is kept as a list of bytes and resolved when complete
    task automatic model_byte(input logic [7:0] b, output bit emit, output logic [9:0] e);
        emit = 0;
        e = '0;
        if (pend.size() == 0) begin
            if (b inside {8'hE0, 8'hF0, 8'hE1}) pend.push_back(b);
            else if (b == 8'hAA) m_kb = 1;
            else if (b inside {8'hFC, 8'h00, 8'hFF}) m_err = sat(m_err);
            else if (!(b inside {8'hFA, 8'hEE})) begin
                emit = 1;
                e = {2'b00, b};
            end
        end else if (pend[0] == 8'hE1) begin
            pend.push_back(b);
            if (pend.size() == 8) begin
                emit = 1;
                e = 10'h177;
                pend.delete();
            end
        end else if (pend.size() == 1 && pend[0] == 8'hE0 && (b inside {8'hE0, 8'hF0})) begin
            if (b == 8'hF0) pend.push_back(b);
        end else begin
            emit = 1;
            e = {pend[pend.size()-1] == 8'hF0, pend[0] == 8'hE0, b};
            pend.delete();
        end
    endtask

    initial forever begin
        bit emit;
        bit pop;
        logic [9:0] e;
        @(posedge clk or posedge rst);
        if (rst) begin
            m_q.delete();
            pend.delete();
            m_kb = 0;
            m_ovf = 0;
            m_err = 0;
            m_cnt = 0;
        end else begin
            pop = ev_ready && m_q.size() > 0;
            emit = 0;
            e = '0;
            if (done) begin
                model_byte(code, emit, e);
                m_cnt = 0;
            end else if (pend.size() > 0) begin
                if (m_cnt == TO - 1) begin
                    pend.delete();
                    m_err = sat(m_err);
                    m_cnt = 0;
                end else m_cnt++;
            end
            if (pop) void'(m_q.pop_front());
            if (emit) begin
                if (m_q.size() < DEPTH) m_q.push_back(e);
                else m_ovf = 1;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        chk("ev_valid", ev_valid, m_q.size() != 0);
        if (m_q.size() > 0) chk("ev_data", ev_data, m_q[0]);
        chk("kb_ready", kb_ready, m_kb);
        chk("overflow", overflow, m_ovf);
        chk("err_cnt", err_cnt, m_err);
    end

    task automatic send(input logic [7:0] b, input logic rdy = 0);
        @(posedge clk);
        #2;
        code = b;
        done = 1;
        ev_ready = rdy;
        @(posedge clk);
        #2;
        done = 0;
        ev_ready = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic drain(input int n);
        @(posedge clk);
        #2;
        ev_ready = 1;
        repeat (n) @(posedge clk);
        #2;
        ev_ready = 0;
    endtask

    initial begin
        logic [7:0] pause_seq [8];
        pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        repeat (2) @(posedge clk);
        #2;
        rst = 0;
        @(negedge clk);
        chk("lit_rst_valid", ev_valid, 0);
        chk("lit_rst_data", ev_data, 0);
        chk("lit_rst_err", err_cnt, 0);
        send(8'h1C);
        @(negedge clk);
        chk("lit_make_valid", ev_valid, 1);
        chk("lit_make_data", ev_data, 10'h01C);
        drain(1);
        @(negedge clk);
        chk("lit_pop_valid", ev_valid, 0);
        send(8'hF0);
        @(negedge clk);
        chk("lit_prefix_noev", ev_valid, 0);
        send(8'h1C);
        @(negedge clk);
        chk("lit_brk", ev_data, 10'h21C);
        drain(1);
        send(8'hE0);
        send(8'hF0);
        send(8'h75);
        @(negedge clk);
        chk("lit_ext_brk", ev_data, 10'h375);
        drain(1);
        send(8'hE0);
        send(8'h75);
        @(negedge clk);
        chk("lit_ext", ev_data, 10'h175);
        drain(1);
        foreach (pause_seq[i]) pause_seq[i] = pause_seq[i];
        send(8'h15); send(8'h16); send(8'h1E); send(8'h26);
        send(8'h2D, 1);
        @(negedge clk);
        chk("lit_full_pushpop_ovf", overflow, 0);
        chk("lit_full_pushpop_head", ev_data, 10'h016);
        drain(5);
        @(negedge clk);
        chk("lit_drained", ev_valid, 0);
        send(8'h15); send(8'h16); send(8'h1E); send(8'h26); send(8'h25);
        @(negedge clk);
        chk("lit_overflow", overflow, 1);
        chk("lit_ovf_head", ev_data, 10'h015);
        drain(6);
        @(negedge clk);
        chk("lit_ovf_dropped", ev_valid, 0);
        send(8'hE0);
        idle(18);
        send(8'h75);
        @(negedge clk);
        chk("lit_to_edge_err", err_cnt, 0);
        chk("lit_to_edge_data", ev_data, 10'h175);
        drain(1);
        send(8'hE0);
        idle(TO + 2);
        @(negedge clk);
        chk("lit_timeout_err", err_cnt, 1);
        send(8'h1C);
        @(negedge clk);
        chk("lit_after_to", ev_data, 10'h01C);
        drain(1);
        for (int i = 0; i < 8; i++) begin
            send(pause_seq[i]);
            if (i == 6) begin
                @(negedge clk);
                chk("lit_pause_pending", ev_valid, 0);
            end
        end
        @(negedge clk);
        chk("lit_pause", ev_data, 10'h177);
        drain(3);
        @(negedge clk);
        chk("lit_pause_once", ev_valid, 0);
        send(8'hAA);
        send(8'hFA);
        send(8'hEE);
        @(negedge clk);
        chk("lit_kb_ready", kb_ready, 1);
        chk("lit_status_noev", ev_valid, 0);
        send(8'hFC);
        send(8'hFF);
        @(negedge clk);
        chk("lit_err_codes", err_cnt, 3);
        for (int i = 0; i < 6; i++) send(8'h00);
        @(negedge clk);
        chk("lit_err_sat", err_cnt, 7);
        send(8'h1C);
        send(8'h32);
        send(8'hE0);
        @(posedge clk);
        #2;
        rst = 1;
        @(negedge clk);
        chk("lit_mid_rst_valid", ev_valid, 0);
        chk("lit_mid_rst_kb", kb_ready, 0);
        chk("lit_mid_rst_err", err_cnt, 0);
        chk("lit_mid_rst_ovf", overflow, 0);
        @(posedge clk);
        #2;
        rst = 0;
        send(8'h1C);
        @(negedge clk);
        chk("lit_post_rst", ev_data, 10'h01C);
        drain(1);
        idle(2);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
